hsem_intr_rx: RTL and testbench

- Core-side receiver for the HSEM per-core interrupt line (intr_0 / intr_1).
- Detects the interrupt and presents it to the core with a cause code. Waits for the core to acknowledge, then runs a clear handshake back to HSEM; the clear request drives the HSEM interrupt-clear enable path.
- Counts interrupts that arrive while one is still being serviced, and flags overflow and acknowledge timeout.
- One instance per core.

---
 rtl/hsem_intr_rx.sv | 146 ++++++++++++++
 tb/tb_hsem_intr_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hsem_intr_rx.sv
// Core-side receiver for one HSEM per-core interrupt line: presents the interrupt with
// a cause code, waits for the core ack, then runs the clear handshake back to HSEM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no interrupt in service
// ASSERT   | irq_out high, waiting for irq_ack or timeout
// CLEAR    | clr_req high, waiting for clr_ack from HSEM
// WAIT_LOW | waiting for the HSEM level to drop before next service
module hsem_intr_rx #(
  parameter int CORE_ID     = 0,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 intr_in,
  input  logic                 err_in,
  input  logic                 irq_ack,
  input  logic                 clr_ack,
  input  logic                 flag_clr,
  output logic                 irq_out,
  output logic [1:0]           irq_cause,
  output logic                 clr_req,
  output logic [CNT_WIDTH-1:0] pend_cnt,
  output logic                 ovf,
  output logic                 tmo,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERT   = 2'd1,
    S_CLEAR    = 2'd2,
    S_WAIT_LOW = 2'd3
  } state_t;

  // CORE_ID only tags the instance; it folds to zero here.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1 + CORE_ID * 0);

  state_t               state, state_nxt;
  logic                 intr_q;
  logic                 armed;
  logic                 evt;
  logic [7:0]           tmo_cnt, tmo_cnt_nxt;
  logic [CNT_WIDTH-1:0] pend_nxt;
  logic                 irq_nxt, clr_nxt, ovf_nxt, tmo_nxt;
  logic [1:0]           cause_nxt;
  logic                 pend_inc, pend_dec;

  // A level still high when reset releases must go low before it can count as an edge.
  assign evt = intr_in & ~intr_q & armed;

  always_comb begin
    state_nxt   = state;
    irq_nxt     = irq_out;
    cause_nxt   = irq_cause;
    clr_nxt     = clr_req;
    tmo_nxt     = tmo & ~flag_clr;
    ovf_nxt     = ovf & ~flag_clr;
    tmo_cnt_nxt = 8'd0;
    pend_inc    = evt & (state != S_IDLE);
    pend_dec    = 1'b0;
    pend_nxt    = pend_cnt;

    case (state)
      S_IDLE: begin
        if (evt) begin
          state_nxt = S_ASSERT;
          irq_nxt   = 1'b1;
          cause_nxt = err_in ? 2'b10 : 2'b01;
        end
      end
      S_ASSERT: begin
        if (irq_ack) begin
          state_nxt = S_CLEAR;
          irq_nxt   = 1'b0;
          clr_nxt   = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = S_CLEAR;
          irq_nxt   = 1'b0;
          clr_nxt   = 1'b1;
          tmo_nxt   = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      S_CLEAR: begin
        if (clr_ack) begin
          state_nxt = S_WAIT_LOW;
          clr_nxt   = 1'b0;
          cause_nxt = 2'b00;
        end
      end
      S_WAIT_LOW: begin
        if (!intr_in) begin
          if (pend_cnt != '0) begin
            state_nxt = S_ASSERT;
            irq_nxt   = 1'b1;
            cause_nxt = err_in ? 2'b10 : 2'b01;
            pend_dec  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (pend_inc && !pend_dec) begin
      if (pend_cnt == '1) ovf_nxt = 1'b1;
      else                pend_nxt = pend_cnt + CNT_WIDTH'(1);
    end else if (pend_dec && !pend_inc) begin
      pend_nxt = pend_cnt - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= S_IDLE;
      intr_q    <= 1'b0;
      armed     <= 1'b0;
      tmo_cnt   <= 8'd0;
      irq_out   <= 1'b0;
      irq_cause <= 2'b00;
      clr_req   <= 1'b0;
      pend_cnt  <= '0;
      ovf       <= 1'b0;
      tmo       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      intr_q    <= intr_in;
      if (!intr_in) armed <= 1'b1;
      tmo_cnt   <= tmo_cnt_nxt;
      irq_out   <= irq_nxt;
      irq_cause <= cause_nxt;
      clr_req   <= clr_nxt;
      pend_cnt  <= pend_nxt;
      ovf       <= ovf_nxt;
      tmo       <= tmo_nxt;
      busy      <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_hsem_intr_rx.sv
// Bench for hsem_intr_rx: cycle vectors of {inputs, expected next-cycle outputs},
// expectations queued at drive time and compared one edge later.
module tb_hsem_intr_rx;

  localparam int CW  = 2;
  localparam int TMO = 16;

  logic          hclk;
  logic          hresetn;
  logic          intr_in, err_in, irq_ack, clr_ack, flag_clr;
  logic          irq_out, clr_req, ovf, tmo, busy;
  logic [1:0]    irq_cause;
  logic [CW-1:0] pend_cnt;

  hsem_intr_rx #(.CORE_ID(1), .TIMEOUT_CYC(TMO), .CNT_WIDTH(CW)) dut (
    .hclk(hclk), .hresetn(hresetn), .intr_in(intr_in), .err_in(err_in),
    .irq_ack(irq_ack), .clr_ack(clr_ack), .flag_clr(flag_clr),
    .irq_out(irq_out), .irq_cause(irq_cause), .clr_req(clr_req),
    .pend_cnt(pend_cnt), .ovf(ovf), .tmo(tmo), .busy(busy)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // in  = {hresetn, intr_in, err_in, irq_ack, clr_ack, flag_clr}
  // out = {irq_out, irq_cause[1:0], clr_req, ovf, tmo, busy}
  typedef struct packed {
    int            rep;
    logic [5:0]    in;
    logic [6:0]    out;
    logic [CW-1:0] pend;
  } vec_t;

  typedef struct packed {
    int            tag;
    logic [6:0]    out;
    logic [CW-1:0] pend;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   step_no = 0;

  task automatic add(input int rep, input logic [5:0] in, input logic [6:0] out, input int pend);
    vec_t v;
    v.rep  = rep;
    v.in   = in;
    v.out  = out;
    v.pend = CW'(pend);
    vecs.push_back(v);
  endtask

  task automatic check_out();
    exp_t e;
    logic [6:0] act;
    act = {irq_out, irq_cause, clr_req, ovf, tmo, busy};
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty at step %0d", step_no);
    end else begin
      e = sb.pop_front();
      if (act === e.out && pend_cnt === e.pend) begin
        n_pass++;
      end else begin
        $display("FAIL step %0d irq/cause/clr/ovf/tmo/busy: got %b pend=%0d, want %b pend=%0d",
                 e.tag, act, pend_cnt, e.out, e.pend);
      end
    end
  endtask

  task automatic step(input logic [5:0] in, input logic [6:0] out, input int pend);
    exp_t e;
    {hresetn, intr_in, err_in, irq_ack, clr_ack, flag_clr} = in;
    e.tag  = step_no;
    e.out  = out;
    e.pend = CW'(pend);
    sb.push_back(e);
    @(posedge hclk);
    #1;
    check_out();
    step_no++;
  endtask

  // mode 0: no ack; mode 1: ack in the final ASSERT cycle; mode 2: flag_clr with the timeout
  task automatic tmo_seq(input int mode);
    logic t;
    t = (mode != 1);
    step(6'b1_1_0_0_0_0, 7'b1_01_0_0_0_1, 0);
    for (int i = 0; i < TMO - 1; i++) step(6'b1_1_0_0_0_0, 7'b1_01_0_0_0_1, 0);
    case (mode)
      0:       step(6'b1_1_0_0_0_0, 7'b0_01_1_0_1_1, 0);
      1:       step(6'b1_1_0_1_0_0, 7'b0_01_1_0_0_1, 0);
      default: step(6'b1_1_0_0_0_1, 7'b0_01_1_0_1_1, 0);
    endcase
    step(6'b1_1_0_0_1_0, {1'b0, 2'b00, 1'b0, 1'b0, t, 1'b1}, 0);
    step(6'b1_0_0_0_0_0, {1'b0, 2'b00, 1'b0, 1'b0, t, 1'b0}, 0);
    step(6'b1_0_0_0_0_1, 7'b0_00_0_0_0_0, 0);
  endtask

  localparam logic [6:0] Z = 7'b0_00_0_0_0_0;
  localparam logic [6:0] A = 7'b1_01_0_0_0_1;   // ASSERT, task-switch cause
  localparam logic [6:0] C = 7'b0_01_1_0_0_1;   // CLEAR, task-switch cause
  localparam logic [6:0] W = 7'b0_00_0_0_0_1;   // WAIT_LOW

  initial begin
    {hresetn, intr_in, err_in, irq_ack, clr_ack, flag_clr} = 6'b0;

    // reset and idle, stray acks ignored
    add(2, 6'b0_0_0_0_0_0, Z, 0);
    add(8, 6'b1_0_0_0_0_0, Z, 0);
    add(1, 6'b1_0_0_1_0_0, Z, 0);
    add(1, 6'b1_0_0_0_1_0, Z, 0);
    // basic task-switch service
    add(1, 6'b1_1_0_0_0_0, A, 0);
    add(2, 6'b1_1_0_0_0_0, A, 0);
    add(1, 6'b1_1_0_0_1_0, A, 0);
    add(1, 6'b1_1_0_1_0_0, C, 0);
    add(2, 6'b1_1_0_0_0_0, C, 0);
    add(1, 6'b1_1_0_1_0_0, C, 0);
    add(1, 6'b1_1_0_0_1_0, W, 0);
    add(2, 6'b1_1_0_0_0_0, W, 0);
    add(1, 6'b1_0_0_0_0_0, Z, 0);
    add(2, 6'b1_0_0_0_0_0, Z, 0);
    // error cause, held through ack
    add(1, 6'b1_1_1_0_0_0, 7'b1_10_0_0_0_1, 0);
    add(1, 6'b1_1_0_1_0_0, 7'b0_10_1_0_0_1, 0);
    add(1, 6'b1_1_0_0_1_0, W, 0);
    add(1, 6'b1_0_0_0_0_0, Z, 0);
    // pending events queued during ASSERT
    add(1, 6'b1_1_0_0_0_0, A, 0);
    add(1, 6'b1_0_0_0_0_0, A, 0);
    add(1, 6'b1_1_0_0_0_0, A, 1);
    add(1, 6'b1_0_0_0_0_0, A, 1);
    add(1, 6'b1_1_0_0_0_0, A, 2);
    add(1, 6'b1_1_0_1_0_0, C, 2);
    add(1, 6'b1_1_0_0_1_0, W, 2);
    add(1, 6'b1_1_0_0_0_0, W, 2);
    add(1, 6'b1_0_1_0_0_0, 7'b1_10_0_0_0_1, 1);
    add(1, 6'b1_0_0_1_0_0, 7'b0_10_1_0_0_1, 1);
    add(1, 6'b1_0_0_0_1_0, W, 1);
    add(1, 6'b1_0_0_0_0_0, A, 0);
    add(1, 6'b1_0_0_1_0_0, C, 0);
    add(1, 6'b1_0_0_0_1_0, W, 0);
    add(1, 6'b1_0_0_0_0_0, Z, 0);
    // overflow at CNT_WIDTH=2, flag clear and set-wins
    add(1, 6'b1_1_0_0_0_0, A, 0);
    add(1, 6'b1_0_0_0_0_0, A, 0);
    add(1, 6'b1_1_0_0_0_0, A, 1);
    add(1, 6'b1_0_0_0_0_0, A, 1);
    add(1, 6'b1_1_0_0_0_0, A, 2);
    add(1, 6'b1_0_0_0_0_0, A, 2);
    add(1, 6'b1_1_0_0_0_0, A, 3);
    add(1, 6'b1_0_0_0_0_0, A, 3);
    add(1, 6'b1_1_0_0_0_0, 7'b1_01_0_1_0_1, 3);
    add(1, 6'b1_1_0_0_0_1, A, 3);
    add(1, 6'b1_0_0_0_0_0, A, 3);
    add(1, 6'b1_1_0_0_0_1, 7'b1_01_0_1_0_1, 3);
    add(1, 6'b1_1_0_0_0_1, A, 3);
    add(1, 6'b1_1_0_1_0_0, C, 3);
    add(1, 6'b1_1_0_0_1_0, W, 3);
    for (int p = 2; p >= 0; p--) begin
      add(1, 6'b1_0_0_0_0_0, A, p);
      add(1, 6'b1_0_0_1_0_0, C, p);
      add(1, 6'b1_0_0_0_1_0, W, p);
    end
    add(1, 6'b1_0_0_0_0_0, Z, 0);
    // reset during CLEAR with intr_in still high
    add(1, 6'b1_1_0_0_0_0, A, 0);
    add(1, 6'b1_0_0_0_0_0, A, 0);
    add(1, 6'b1_1_0_0_0_0, A, 1);
    add(1, 6'b1_1_0_1_0_0, C, 1);
    add(1, 6'b0_1_0_0_1_0, Z, 0);
    add(3, 6'b1_1_0_0_0_0, Z, 0);
    add(1, 6'b1_0_0_0_0_0, Z, 0);
    add(1, 6'b1_1_0_0_0_0, A, 0);
    add(1, 6'b1_1_0_1_0_0, C, 0);
    add(1, 6'b1_1_0_0_1_0, W, 0);
    add(1, 6'b1_0_0_0_0_0, Z, 0);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) step(vecs[i].in, vecs[i].out, int'(vecs[i].pend));
    end

    tmo_seq(0);
    tmo_seq(1);
    tmo_seq(2);

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
